// File: rtl/aw_video_pkg.sv
// Shared types, op codes and page-resolution helper for the video command engine.
package aw_video_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned ARG_W   = 8;
    localparam int unsigned PAGE_W  = 2;
    localparam int unsigned COLOR_W = 4;
    localparam int unsigned PAL_W   = 5;

    localparam logic [OP_W-1:0] OP_SELECT = 3'd0;
    localparam logic [OP_W-1:0] OP_FILL   = 3'd1;
    localparam logic [OP_W-1:0] OP_COPY   = 3'd2;
    localparam logic [OP_W-1:0] OP_BLIT   = 3'd3;
    localparam logic [OP_W-1:0] OP_SETPAL = 3'd4;

    localparam logic [ARG_W-1:0] PAGE_CUR  = 8'hFE;
    localparam logic [ARG_W-1:0] PAGE_BACK = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL       = 3'd1,
        ST_COPY       = 3'd2,
        ST_COPY_DRAIN = 3'd3,
        ST_BLIT_WAIT  = 3'd4
    } state_t;

    // Command context captured at acceptance and used while the command runs.
    typedef struct packed {
        logic [PAGE_W-1:0]  src;
        logic [PAGE_W-1:0]  dst;
        logic [COLOR_W-1:0] colour;
        logic               blit_swap;
        logic [PAGE_W-1:0]  blit_page;
    } cmd_ctx_t;

    // Maps a page argument to a physical page; 0xFE/0xFF alias the work/back pages.
    function automatic logic [PAGE_W-1:0] resolve_page(
        input logic [ARG_W-1:0]  p,
        input logic [PAGE_W-1:0] work,
        input logic [PAGE_W-1:0] back
    );
        logic [PAGE_W-1:0] r;
        r = p[PAGE_W-1:0];
        if (p == PAGE_CUR) begin
            r = work;
        end else if (p == PAGE_BACK) begin
            r = back;
        end
        return r;
    endfunction

endpackage

// File: rtl/aw_page_sweep.sv
// Pixel index counter shared by the fill and copy sweeps; saturates at the last pixel.
module aw_page_sweep #(
    parameter int unsigned NPIX  = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    output logic [CNT_W-1:0] index,
    output logic             done_c
);

    assign done_c = (index == CNT_W'(NPIX - 1));

    // Restart at zero on start, otherwise advance one pixel per step until the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            index <= '0;
        end else if (start) begin
            index <= '0;
        end else if (step && !done_c) begin
            index <= index + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aw_video_cmd_engine.sv
// Executes VM video opcodes against a 4-page, 4-bpp framebuffer and owns the page/palette state.
module aw_video_cmd_engine
    import aw_video_pkg::*;
#(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 200,
    parameter int unsigned ADDR_W = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [ARG_W-1:0]    cmd_arg0,
    input  logic [ARG_W-1:0]    cmd_arg1,
    input  logic                vblank,
    output logic [ADDR_W-1:0]   fb_raddr,
    output logic                fb_re,
    input  logic [COLOR_W-1:0]  fb_rdata,
    output logic [ADDR_W-1:0]   fb_waddr,
    output logic [COLOR_W-1:0]  fb_wdata,
    output logic                fb_we,
    output logic [PAGE_W-1:0]   work_page,
    output logic [PAGE_W-1:0]   display_page,
    output logic [PAL_W-1:0]    palette_id,
    output logic                palette_strobe,
    output logic                busy
);

    localparam int unsigned NPIX  = WIDTH * HEIGHT;
    localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    // Linear framebuffer address of pixel n in a page, truncated to the bus width.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [PAGE_W-1:0] page,
                                                   input logic [CNT_W-1:0] n);
        return ADDR_W'(ADDR_W'(page) * ADDR_W'(NPIX) + ADDR_W'(n));
    endfunction

    state_t state, state_n;

    logic [PAGE_W-1:0]  work_q, work_n;
    logic [PAGE_W-1:0]  back_q, back_n;
    logic [PAGE_W-1:0]  disp_q, disp_n;
    logic [PAL_W-1:0]   pal_q, pal_n;
    logic               strobe_q, strobe_n;
    logic               re_q, re_n;
    logic               we_q, we_n;
    logic [ADDR_W-1:0]  raddr_q, raddr_n;
    logic [ADDR_W-1:0]  waddr_q, waddr_n;
    logic [COLOR_W-1:0] wdata_q, wdata_n;
    logic               copy_wr_q, copy_wr_n;
    cmd_ctx_t           ctx_q, ctx_n;

    logic               sweep_start, sweep_step, sweep_done_c;
    logic [CNT_W-1:0]   sweep_idx, idx_inc;
    logic [PAGE_W-1:0]  res0, res1;

    aw_page_sweep #(
        .NPIX  (NPIX),
        .CNT_W (CNT_W)
    ) u_sweep (
        .clk    (clk),
        .reset  (reset),
        .start  (sweep_start),
        .step   (sweep_step),
        .index  (sweep_idx),
        .done_c (sweep_done_c)
    );

    assign idx_inc = sweep_idx + CNT_W'(1);
    assign res0    = resolve_page(cmd_arg0, work_q, back_q);
    assign res1    = resolve_page(cmd_arg1, work_q, back_q);

    assign cmd_ready      = (state == ST_IDLE);
    assign busy           = ~cmd_ready;
    assign fb_raddr       = raddr_q;
    assign fb_re          = re_q;
    assign fb_waddr       = waddr_q;
    assign fb_we          = we_q;
    // Copy writes forward the read data straight through; it arrives in the write cycle.
    assign fb_wdata       = copy_wr_q ? fb_rdata : wdata_q;
    assign work_page      = work_q;
    assign display_page   = disp_q;
    assign palette_id     = pal_q;
    assign palette_strobe = strobe_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output decode; outputs are computed one cycle ahead.
    always_comb begin
        state_n     = state;
        work_n      = work_q;
        back_n      = back_q;
        disp_n      = disp_q;
        pal_n       = pal_q;
        strobe_n    = 1'b0;
        re_n        = 1'b0;
        we_n        = 1'b0;
        raddr_n     = raddr_q;
        waddr_n     = waddr_q;
        wdata_n     = wdata_q;
        copy_wr_n   = 1'b0;
        ctx_n       = ctx_q;
        sweep_start = 1'b0;
        sweep_step  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_SELECT: begin
                            work_n = res0;
                        end
                        OP_SETPAL: begin
                            pal_n    = cmd_arg0[PAL_W-1:0];
                            strobe_n = 1'b1;
                        end
                        OP_FILL: begin
                            ctx_n.dst    = res0;
                            ctx_n.colour = cmd_arg1[COLOR_W-1:0];
                            sweep_start  = 1'b1;
                            we_n         = 1'b1;
                            waddr_n      = pix_addr(res0, '0);
                            wdata_n      = cmd_arg1[COLOR_W-1:0];
                            state_n      = ST_FILL;
                        end
                        OP_COPY: begin
                            ctx_n.src   = res0;
                            ctx_n.dst   = res1;
                            sweep_start = 1'b1;
                            re_n        = 1'b1;
                            raddr_n     = pix_addr(res0, '0);
                            state_n     = ST_COPY;
                        end
                        OP_BLIT: begin
                            ctx_n.blit_swap = (cmd_arg0 == PAGE_BACK);
                            ctx_n.blit_page = res0;
                            state_n         = ST_BLIT_WAIT;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_FILL: begin
                if (sweep_done_c) begin
                    state_n = ST_IDLE;
                end else begin
                    sweep_step = 1'b1;
                    we_n       = 1'b1;
                    waddr_n    = pix_addr(ctx_q.dst, idx_inc);
                    wdata_n    = ctx_q.colour;
                end
            end
            ST_COPY: begin
                // The pixel read this cycle becomes the write of the next cycle.
                we_n      = 1'b1;
                copy_wr_n = 1'b1;
                waddr_n   = pix_addr(ctx_q.dst, sweep_idx);
                if (sweep_done_c) begin
                    state_n = ST_COPY_DRAIN;
                end else begin
                    sweep_step = 1'b1;
                    re_n       = 1'b1;
                    raddr_n    = pix_addr(ctx_q.src, idx_inc);
                end
            end
            ST_COPY_DRAIN: begin
                state_n = ST_IDLE;
            end
            ST_BLIT_WAIT: begin
                if (vblank) begin
                    if (ctx_q.blit_swap) begin
                        disp_n = back_q;
                        back_n = disp_q;
                    end else begin
                        disp_n = ctx_q.blit_page;
                    end
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Page, palette and framebuffer port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q    <= 2'd0;
            back_q    <= 2'd1;
            disp_q    <= 2'd2;
            pal_q     <= '0;
            strobe_q  <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            copy_wr_q <= 1'b0;
            ctx_q     <= '0;
        end else begin
            work_q    <= work_n;
            back_q    <= back_n;
            disp_q    <= disp_n;
            pal_q     <= pal_n;
            strobe_q  <= strobe_n;
            re_q      <= re_n;
            we_q      <= we_n;
            raddr_q   <= raddr_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            copy_wr_q <= copy_wr_n;
            ctx_q     <= ctx_n;
        end
    end

endmodule

// File: tb/tb_aw_video_cmd_engine.sv
// Bench for aw_video_cmd_engine on a 4x2 page geometry with a bench-owned framebuffer.
module tb_aw_video_cmd_engine;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned HEIGHT = 2;
    localparam int unsigned NPIX   = WIDTH * HEIGHT;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NWORDS = 4 * NPIX;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = 3'd0;
    logic [7:0]        cmd_arg0 = 8'd0;
    logic [7:0]        cmd_arg1 = 8'd0;
    logic              vblank = 1'b0;
    logic [ADDR_W-1:0] fb_raddr;
    logic              fb_re;
    logic [3:0]        fb_rdata;
    logic [ADDR_W-1:0] fb_waddr;
    logic [3:0]        fb_wdata;
    logic              fb_we;
    logic [1:0]        work_page;
    logic [1:0]        display_page;
    logic [4:0]        palette_id;
    logic              palette_strobe;
    logic              busy;

    // Bench framebuffer with a preload port.
    logic [3:0]        ram [0:NWORDS-1];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [3:0]        pre_data = '0;

    // Reference model state.
    logic [3:0] exp_mem [0:NWORDS-1];
    logic [1:0] exp_work, exp_back, exp_disp;
    logic [4:0] exp_pal;

    int n_cmp = 0;
    int n_bad = 0;

    aw_video_cmd_engine #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_arg0       (cmd_arg0),
        .cmd_arg1       (cmd_arg1),
        .vblank         (vblank),
        .fb_raddr       (fb_raddr),
        .fb_re          (fb_re),
        .fb_rdata       (fb_rdata),
        .fb_waddr       (fb_waddr),
        .fb_wdata       (fb_wdata),
        .fb_we          (fb_we),
        .work_page      (work_page),
        .display_page   (display_page),
        .palette_id     (palette_id),
        .palette_strobe (palette_strobe),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Framebuffer: synchronous write, read data one cycle after fb_re.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (fb_we) begin
            ram[fb_waddr] <= fb_wdata;
        end
        if (fb_re) begin
            fb_rdata <= ram[fb_raddr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] res(input logic [7:0] p);
        if (p == 8'hFE) return exp_work;
        if (p == 8'hFF) return exp_back;
        return p[1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] p, input int k);
        return ADDR_W'(int'(p) * NPIX + k);
    endfunction

    function automatic logic [7:0] rand_page();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel < 4) return 8'(sel);
        if (sel == 4) return 8'hFE;
        if (sel == 5) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic model_reset();
        exp_work = 2'd0;
        exp_back = 2'd1;
        exp_disp = 2'd2;
        exp_pal  = 5'd0;
    endtask

    task automatic poke(input int a, input logic [3:0] d);
        pre_we   = 1'b1;
        pre_addr = ADDR_W'(a);
        pre_data = d;
        exp_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Presents one command at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic send(input logic [2:0] op, input logic [7:0] a0, input logic [7:0] a1, input logic vb);
        check("ready_before_cmd", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg0  = a0;
        cmd_arg1  = a1;
        vblank    = vb;
        @(negedge clk);
        cmd_valid = 1'b0;
        vblank    = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg0  = 8'd0;
        cmd_arg1  = 8'd0;
    endtask

    task automatic do_fill(input logic [7:0] a0, input logic [7:0] a1);
        logic [1:0] p;
        p = res(a0);
        send(3'd1, a0, a1, 1'b0);
        for (int k = 0; k < int'(NPIX); k++) begin
            check("fill_write", 32'({fb_we, fb_re, busy, fb_wdata, fb_waddr}),
                  32'({1'b1, 1'b0, 1'b1, a1[3:0], addr_of(p, k)}));
            exp_mem[int'(addr_of(p, k))] = a1[3:0];
            @(negedge clk);
        end
        check("fill_end", 32'({cmd_ready, fb_we, fb_re}), 32'(3'b100));
    endtask

    task automatic do_copy(input logic [7:0] a0, input logic [7:0] a1);
        logic [1:0] s, d;
        logic [3:0] snap [0:NWORDS-1];
        s = res(a0);
        d = res(a1);
        for (int i = 0; i < int'(NWORDS); i++) snap[i] = exp_mem[i];
        send(3'd2, a0, a1, 1'b0);
        for (int c = 0; c <= int'(NPIX); c++) begin
            check("copy_busy", 32'(busy), 32'(1));
            if (c < int'(NPIX)) begin
                check("copy_read", 32'({fb_re, fb_raddr}), 32'({1'b1, addr_of(s, c)}));
            end else begin
                check("copy_read_off", 32'(fb_re), 32'(0));
            end
            if (c >= 1) begin
                check("copy_write", 32'({fb_we, fb_waddr, fb_wdata}),
                      32'({1'b1, addr_of(d, c - 1), snap[int'(addr_of(s, c - 1))]}));
                exp_mem[int'(addr_of(d, c - 1))] = snap[int'(addr_of(s, c - 1))];
            end else begin
                check("copy_write_off", 32'(fb_we), 32'(0));
            end
            @(negedge clk);
        end
        check("copy_end", 32'({cmd_ready, fb_we, fb_re}), 32'(3'b100));
    endtask

    task automatic do_blit(input logic [7:0] a0, input int dly, input logic vb_acc);
        logic [1:0] old_disp, t;
        old_disp = exp_disp;
        send(3'd3, a0, 8'h00, vb_acc);
        for (int i = 0; i < dly; i++) begin
            check("blit_wait", 32'({busy, fb_we, fb_re, display_page}), 32'({3'b100, old_disp}));
            @(negedge clk);
        end
        vblank = 1'b1;
        check("blit_vblank_cycle", 32'({busy, display_page}), 32'({1'b1, old_disp}));
        @(negedge clk);
        vblank = 1'b0;
        if (a0 == 8'hFF) begin
            t = exp_disp;
            exp_disp = exp_back;
            exp_back = t;
        end else begin
            exp_disp = res(a0);
        end
        check("blit_done", 32'({cmd_ready, display_page}), 32'({1'b1, exp_disp}));
    endtask

    task automatic do_select(input logic [7:0] a0);
        exp_work = res(a0);
        send(3'd0, a0, 8'h00, 1'b0);
        check("select", 32'({cmd_ready, work_page}), 32'({1'b1, exp_work}));
    endtask

    task automatic do_setpal(input logic [7:0] a0);
        exp_pal = a0[4:0];
        send(3'd4, a0, 8'h00, 1'b0);
        check("setpal_pulse", 32'({cmd_ready, palette_strobe, palette_id}), 32'({2'b11, exp_pal}));
        @(negedge clk);
        check("setpal_after", 32'({cmd_ready, palette_strobe, palette_id}), 32'({2'b10, exp_pal}));
    endtask

    task automatic do_reserved(input logic [2:0] op);
        send(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        check("reserved", 32'({cmd_ready, palette_strobe, fb_we, fb_re, work_page, display_page, palette_id}),
              32'({4'b1000, exp_work, exp_disp, exp_pal}));
    endtask

    initial begin
        logic [2:0] op;
        logic [1:0] p;

        // Reset, preloading the framebuffer with random pixels meanwhile.
        model_reset();
        for (int i = 0; i < int'(NWORDS); i++) poke(i, 4'($urandom_range(0, 15)));
        @(negedge clk);
        check("reset_ctrl", 32'({cmd_ready, busy, fb_we, fb_re, palette_strobe}), 32'(5'b10000));
        check("reset_regs", 32'({work_page, display_page, palette_id}), 32'({2'd0, 2'd2, 5'd0}));
        check("reset_bus", 32'({fb_waddr, fb_raddr, fb_wdata}), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        do_fill(8'd3, 8'h0A);
        do_select(8'hFF);
        do_fill(8'hFE, 8'h05);

        for (int i = 0; i < int'(NPIX); i++) poke(i, 4'(i));
        do_copy(8'd0, 8'd2);

        do_blit(8'hFF, 4, 1'b0);
        do_fill(8'hFF, 8'h07);
        do_blit(8'h00, $urandom_range(0, 5), 1'b0);
        do_blit(8'd1, 2, 1'b1);

        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        check("idle_vblank", 32'({cmd_ready, display_page}), 32'({1'b1, exp_disp}));

        do_setpal(8'h3F);
        do_reserved(3'd6);

        // Reset in the middle of a fill.
        p = res(8'd1);
        send(3'd1, 8'd1, 8'h0C, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("fill_pre_reset", 32'({fb_we, fb_waddr}), 32'({1'b1, addr_of(p, k)}));
            exp_mem[int'(addr_of(p, k))] = 4'hC;
            @(negedge clk);
        end
        exp_mem[int'(addr_of(p, 3))] = 4'hC;
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check("midreset_ctrl", 32'({cmd_ready, busy, fb_we, fb_re, palette_strobe}), 32'(5'b10000));
        check("midreset_regs", 32'({work_page, display_page, palette_id}), 32'({2'd0, 2'd2, 5'd0}));
        check("midreset_bus", 32'({fb_waddr, fb_raddr, fb_wdata}), 32'(0));
        reset = 1'b0;
        do_fill(8'd2, 8'h03);

        // Random command stream.
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            case (op)
                3'd0:    do_select(rand_page());
                3'd1:    do_fill(rand_page(), 8'($urandom_range(0, 255)));
                3'd2:    do_copy(rand_page(), rand_page());
                3'd3:    do_blit(rand_page(), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
                3'd4:    do_setpal(8'($urandom_range(0, 255)));
                default: do_reserved(op);
            endcase
        end

        @(negedge clk);
        for (int i = 0; i < int'(NWORDS); i++) begin
            check($sformatf("mem_%0d", i), 32'(ram[i]), 32'(exp_mem[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aw_video_cmd_engine.md
Name: aw_video_cmd_engine

Overview:
- Responder for the VM's video opcodes: selectVideoPage, fillVideoPage, copyVideoPage, blitFrameBuffer and setPalette.
- Accepts one command at a time from the bytecode CPU over a valid/ready handshake.
- Executes commands against an external 4-page, 4-bpp framebuffer RAM.
- Owns the work-page, back-page and display-page registers and the palette selection that feeds the scanout path.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 200, lines per page.
- NPIX, WIDTH*HEIGHT, pixels per page.
- ADDR_W, 18, framebuffer address width; must satisfy 4*NPIX <= 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  3  0=SELECT, 1=FILL, 2=COPY, 3=BLIT, 4=SETPAL, 5-7 reserved.
- cmd_arg0  in  8  page id (SELECT/FILL/BLIT), source page (COPY), palette id (SETPAL).
- cmd_arg1  in  8  colour in [3:0] (FILL), destination page (COPY).
- vblank  in  1  one-cycle pulse at start of vertical blank.
- fb_raddr  out  ADDR_W  framebuffer read address.
- fb_re  out  1  read enable.
- fb_rdata  in  4  read data, valid exactly 1 cycle after fb_re.
- fb_waddr  out  ADDR_W  write address.
- fb_wdata  out  4  write data.
- fb_we  out  1  write enable.
- work_page  out  2  current drawing page.
- display_page  out  2  page shown by scanout.
- palette_id  out  5  selected palette.
- palette_strobe  out  1  one-cycle pulse when palette_id changes.
- busy  out  1  equals ~cmd_ready.

Behaviour:
- Reset values: work_page=0, back_page (internal)=1, display_page=2, palette_id=0, palette_strobe=0, fb_we=0, fb_re=0, all addresses and fb_wdata=0, state=IDLE, cmd_ready=1.
- Reset asserted mid-command aborts it; fb_we and fb_re are 0 on the cycle after reset is sampled.
- Page resolution R(p):
  - p<4 gives p[1:0].
  - 0xFE gives work_page.
  - 0xFF gives back_page.
  - Any other value gives p[1:0].
- Handshake: a command is accepted on a cycle where cmd_valid & cmd_ready. cmd_ready = (state==IDLE). Arguments are latched at acceptance.
- SELECT: work_page <= R(arg0) at acceptance; stays IDLE; zero busy cycles.
- SETPAL: palette_id <= arg0[4:0]; palette_strobe=1 on the following cycle only; stays IDLE.
- Reserved ops: accepted, no effect.
- FILL, state FILL:
  - Counter n runs 0..NPIX-1, one write per cycle.
  - fb_waddr = R(arg0)*NPIX + n, fb_wdata = arg1[3:0].
  - The first write is on the cycle after acceptance. Returns to IDLE after the write of n=NPIX-1.
  - Busy for exactly NPIX cycles.
- COPY, state COPY then COPY_DRAIN:
  - Source s=R(arg0) and destination d=R(arg1) are resolved at acceptance.
  - Read n is issued at cycle t+1+n. Write n (fb_waddr=d*NPIX+n, fb_wdata=fb_rdata) follows one cycle later.
  - COPY_DRAIN performs the final write.
  - Busy NPIX+1 cycles; throughput 1 pixel/cycle.
  - s==d is executed normally, with no special case.
- BLIT, state BLIT_WAIT:
  - Waits for vblank. vblank is sampled only in BLIT_WAIT, so a pulse on the acceptance cycle is ignored.
  - On vblank, if arg0==0xFF, display_page and back_page swap. Otherwise display_page <= R(arg0) and back_page is unchanged.
  - Returns to IDLE on the cycle after the vblank.
- vblank outside BLIT_WAIT has no effect.
- Address arithmetic is unsigned, truncated to ADDR_W. Counter width is clog2(NPIX). No wrap beyond NPIX-1.
- fb_re and fb_we are never asserted in IDLE or BLIT_WAIT.

Decomposition:
- Shared package aw_video_pkg:
  - Op codes (OP_SELECT..OP_SETPAL).
  - Page aliases PAGE_CUR=8'hFE and PAGE_BACK=8'hFF.
  - The state enum.
- One natural sub-module, aw_page_sweep: a pixel counter with start, done and index outputs, reused by FILL and COPY.
- Page resolution is a combinational function in the package.

Test Plan (WIDTH=4, HEIGHT=2, NPIX=8, ADDR_W=5):
- Reset, then FILL arg0=3 arg1=0xA → fb_we high 8 consecutive cycles; addresses 24..31; data 0xA; cmd_ready returns 1 on cycle 9 after acceptance.
- SELECT 0xFF, then FILL 0xFE colour 5 → work_page=1; writes to addresses 8..15.
- Preload page 0 with 0..7, then COPY arg0=0 arg1=2 → reads 0..7; writes 16..23 with data 0..7 each one cycle after its read; busy for 9 cycles.
- BLIT 0xFF with vblank pulsed 5 cycles later → display_page stays 2 until then, then becomes 1, with back_page 2; BLIT 0x00 then vblank → display_page=0.
- SETPAL 0x3F → palette_id=0x1F; palette_strobe is a single-cycle pulse; cmd_ready stays 1; reserved op 6 is accepted with no output change.
- Reset asserted midway through a FILL → fb_we=0 on the next cycle; all outputs at their reset values; a new FILL is accepted immediately after reset deasserts.
